// File: rtl/axil_cfg_master_pkg.sv
// Shared types and AXI response codes for the AXI4-Lite configuration master.
`include "defines.sv"

package axil_cfg_master_pkg;

  // Controller states; one transaction in flight at most.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_WRESP = 3'd2,
    ST_READ  = 3'd3,
    ST_RDATA = 3'd4,
    ST_RESP  = 3'd5
  } state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Any response other than OKAY is reported to the requester as an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp != AXI_RESP_OKAY);
  endfunction

endpackage

// File: rtl/defines.sv
// Global width defines shared by the CSR access path.
`ifndef AXIL_CFG_DEFINES_SV
`define AXIL_CFG_DEFINES_SV

`define CSR_ADDR_WIDTH 32
`define DATA_WIDTH     32

`endif

// File: rtl/axil_cfg_master.sv
// AXI4-Lite master turning single CSR read/write commands into AXI transactions.
// Optional watchdog: define AXIL_CFG_TIMEOUT_EN to abort a stalled transaction
// after TIMEOUT_CYCLES cycles with rsp_err set.
`include "defines.sv"

module axil_cfg_master
  import axil_cfg_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = `CSR_ADDR_WIDTH,
  parameter int DATA_WIDTH     = `DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e                  state_q, state_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic                    bready_q, bready_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    tmo_hit_s;

`ifdef AXIL_CFG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          active_s;

  assign active_s  = (state_q == ST_WRITE) || (state_q == ST_WRESP) ||
                     (state_q == ST_READ)  || (state_q == ST_RDATA);
  assign tmo_hit_s = active_s && (tmo_cnt_q == TMO_LAST);

  // Watchdog count: zero while idle, counts every cycle an AXI phase is pending.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == ST_IDLE) begin
      tmo_cnt_d = '0;
    end else if (active_s) begin
      tmo_cnt_d = tmo_cnt_q + TMO_ONE;
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Next-state and output-register computation for the transaction FSM.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    if (tmo_hit_s) begin
      // Abandon the stalled phase and report an error to the requester.
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      bready_d    = 1'b0;
      arvalid_d   = 1'b0;
      rready_d    = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
      rsp_rdata_d = '0;
      state_d     = ST_RESP;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_d = 1'b0;
            addr_d      = cmd_addr;
            wdata_d     = cmd_wdata;
            if (cmd_write) begin
              awvalid_d = 1'b1;
              wvalid_d  = 1'b1;
              aw_done_d = 1'b0;
              w_done_d  = 1'b0;
              state_d   = ST_WRITE;
            end else begin
              arvalid_d = 1'b1;
              state_d   = ST_READ;
            end
          end else begin
            cmd_ready_d = 1'b1;
          end
        end
        ST_WRITE: begin
          // AW and W complete independently; B phase starts once both are done.
          if (awvalid_q && m_axi_awready) begin
            awvalid_d = 1'b0;
            aw_done_d = 1'b1;
          end else begin
            aw_done_d = aw_done_q;
          end
          if (wvalid_q && m_axi_wready) begin
            wvalid_d = 1'b0;
            w_done_d = 1'b1;
          end else begin
            w_done_d = w_done_q;
          end
          if (aw_done_q && w_done_q) begin
            bready_d = 1'b1;
            state_d  = ST_WRESP;
          end else begin
            state_d  = ST_WRITE;
          end
        end
        ST_WRESP: begin
          if (bready_q && m_axi_bvalid) begin
            bready_d    = 1'b0;
            rsp_err_d   = resp_is_err(m_axi_bresp);
            rsp_rdata_d = '0;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end else begin
            state_d = ST_WRESP;
          end
        end
        ST_READ: begin
          if (arvalid_q && m_axi_arready) begin
            arvalid_d = 1'b0;
            rready_d  = 1'b1;
            state_d   = ST_RDATA;
          end else begin
            state_d = ST_READ;
          end
        end
        ST_RDATA: begin
          if (rready_q && m_axi_rvalid) begin
            rready_d    = 1'b0;
            rsp_rdata_d = m_axi_rdata;
            rsp_err_d   = resp_is_err(m_axi_rresp);
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end else begin
            state_d = ST_RDATA;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_d = 1'b0;
            cmd_ready_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_RESP;
          end
        end
        default: begin
          awvalid_d   = 1'b0;
          wvalid_d    = 1'b0;
          bready_d    = 1'b0;
          arvalid_d   = 1'b0;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      endcase
    end
  end

  // FSM and output registers; reset aborts any transaction and returns to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_err       = rsp_err_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = {(DATA_WIDTH/8){1'b1}};
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axil_cfg_master.sv
// Self-checking bench for axil_cfg_master: reactive AXI4-Lite slave model plus
// a response scoreboard filled when commands are issued.
`timescale 1ns/1ps

module tb_axil_cfg_master;
  import axil_cfg_master_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = 32'h0, cmd_wdata = 32'h0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  axil_cfg_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  // Slave knobs and observations.
  int          aw_dly = 0, w_dly = 0, aw_age = 0, w_age = 0;
  bit          silent = 1'b0, b_hold = 1'b0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [31:0] cfg_rdata = 32'h0, exp_addr = 32'h0, exp_wdata = 32'h0;
  int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, late_valid = 0, unstable = 0;
  logic        got_aw, got_w;
  logic [31:0] seen_awaddr = 32'h0, seen_wdata = 32'h0, seen_araddr = 32'h0;
  logic [3:0]  seen_wstrb = 4'h0;
  logic [2:0]  seen_awprot = 3'h7, seen_arprot = 3'h7;

  int n_total = 0, n_bad = 0;
  logic [32:0] sb_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reactive AXI4-Lite slave with configurable ready delays and responses.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
      arready <= 1'b0; rvalid <= 1'b0; rdata <= 32'h0; rresp <= 2'b00;
      got_aw <= 1'b0; got_w <= 1'b0; aw_age <= 0; w_age <= 0;
    end else begin
      if (awvalid && awready) begin
        aw_hs <= aw_hs + 1; got_aw <= 1'b1; seen_awaddr <= awaddr; seen_awprot <= awprot;
        awready <= (aw_dly == 0) && !silent; aw_age <= 0;
      end else if (silent) awready <= 1'b0;
      else if (aw_dly == 0) awready <= 1'b1;
      else if (awvalid) begin awready <= (aw_age >= aw_dly); aw_age <= aw_age + 1; end
      else begin awready <= 1'b0; aw_age <= 0; end

      if (wvalid && wready) begin
        w_hs <= w_hs + 1; got_w <= 1'b1; seen_wdata <= wdata; seen_wstrb <= wstrb;
        wready <= (w_dly == 0) && !silent; w_age <= 0;
      end else if (silent) wready <= 1'b0;
      else if (w_dly == 0) wready <= 1'b1;
      else if (wvalid) begin wready <= (w_age >= w_dly); w_age <= w_age + 1; end
      else begin wready <= 1'b0; w_age <= 0; end

      if ((awvalid && got_aw) || (wvalid && got_w)) late_valid <= late_valid + 1;
      if ((awvalid && awaddr !== exp_addr) || (wvalid && wdata !== exp_wdata) ||
          (arvalid && araddr !== exp_addr)) unstable <= unstable + 1;

      if (bvalid && bready) begin bvalid <= 1'b0; b_hs <= b_hs + 1; end
      else if (got_aw && got_w && !bvalid && !b_hold) begin
        bvalid <= 1'b1; bresp <= cfg_bresp; got_aw <= 1'b0; got_w <= 1'b0;
      end

      arready <= !silent;
      if (arvalid && arready) begin
        ar_hs <= ar_hs + 1; seen_araddr <= araddr; seen_arprot <= arprot;
        rvalid <= 1'b1; rdata <= cfg_rdata; rresp <= cfg_rresp;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0; r_hs <= r_hs + 1;
      end
    end
  end

  // Issue one command, then wait for and score its response.
  task automatic do_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_lat, input int hold);
    int guard;
    int lat;
    logic [32:0] exp;
    sb_q.push_back({exp_err, exp_rd});
    exp_addr = a; exp_wdata = d;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    guard = 0;
    while (!cmd_ready && guard < 50) begin @(negedge clk); guard++; end
    chk("cmd_accept", cmd_ready, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("rsp_seen", rsp_valid, 1'b1);
    if (exp_lat >= 0) chk("latency", lat, exp_lat);
    exp = sb_q[0];
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", rsp_valid, 1'b1);
      chk("hold_rdata", rsp_rdata, exp[31:0]);
      chk("hold_cmd_ready", cmd_ready, 1'b0);
    end
    exp = sb_q.pop_front();
    chk("rsp_rdata", rsp_rdata, exp[31:0]);
    chk("rsp_err", rsp_err, exp[32]);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid, 1'b0);
  endtask

  initial begin
    int p_aw, p_w, p_ar, p_b;
    logic wr, e;
    logic [31:0] a, d;

    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 6'b0);
    chk("rst_rsp", {rsp_err, rsp_rdata}, 33'h0);
    chk("rst_addr", awaddr, 32'h0);
    repeat (2) @(posedge clk);

    // Basic write, slave always ready.
    do_cmd(1'b1, 32'h8, 32'h5, 32'h0, 1'b0, 3, 0);
    chk("wr_aw_hs", aw_hs, 1); chk("wr_w_hs", w_hs, 1); chk("wr_b_hs", b_hs, 1);
    chk("wr_awaddr", seen_awaddr, 32'h8); chk("wr_wdata", seen_wdata, 32'h5);
    chk("wr_wstrb", seen_wstrb, 4'hF); chk("wr_awprot", seen_awprot, 3'b000);

    // Write with W accepted well after AW.
    w_dly = 4;
    do_cmd(1'b1, 32'hC, 32'hA5A5_0001, 32'h0, 1'b0, -1, 0);
    chk("dly_aw_hs", aw_hs, 2); chk("dly_w_hs", w_hs, 2);
    chk("dly_wdata", seen_wdata, 32'hA5A5_0001);
    w_dly = 0;

    // Write with error response, response held off for 5 cycles.
    cfg_bresp = AXI_RESP_SLVERR;
    do_cmd(1'b1, 32'h20, 32'h1234_5678, 32'h0, 1'b1, 3, 5);
    cfg_bresp = AXI_RESP_OKAY;

    // Reads: OKAY, SLVERR, and held response.
    cfg_rdata = 32'hDEAD_BEEF;
    do_cmd(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 0);
    chk("rd_araddr", seen_araddr, 32'h10); chk("rd_arprot", seen_arprot, 3'b000);
    cfg_rresp = AXI_RESP_SLVERR;
    do_cmd(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b1, 2, 0);
    cfg_rresp = AXI_RESP_OKAY; cfg_rdata = 32'h0BAD_F00D;
    do_cmd(1'b0, 32'h44, 32'h0, 32'h0BAD_F00D, 1'b0, 2, 5);

    // Mixed random traffic.
    for (int i = 0; i < 6; i++) begin
      wr = 1'($urandom_range(0, 1));
      e  = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 63)) << 2;
      d  = $urandom;
      cfg_rdata = $urandom;
      cfg_bresp = e ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      cfg_rresp = e ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      do_cmd(wr, a, d, wr ? 32'h0 : cfg_rdata, e, wr ? 3 : 2, i % 3);
    end
    cfg_bresp = AXI_RESP_OKAY; cfg_rresp = AXI_RESP_OKAY;
    chk("late_valid", late_valid, 0);
    chk("unstable", unstable, 0);
    chk("hs_balance", aw_hs + ar_hs, b_hs + r_hs);

    // Reset while waiting for B: everything drops, nothing is replayed.
    b_hold = 1'b1;
    exp_addr = 32'h30; exp_wdata = 32'h77;
    @(negedge clk); cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h30; cmd_wdata = 32'h77;
    @(posedge clk); #1; cmd_valid = 1'b0;
    for (int i = 0; i < 20 && !bready; i++) begin @(posedge clk); #1; end
    chk("wresp_reached", bready, 1'b1);
    p_aw = aw_hs; p_w = w_hs; p_b = b_hs; p_ar = ar_hs;
    rst_n = 1'b0; #1;
    chk("rstmid_async", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 6'b0);
    @(posedge clk); #1;
    chk("rstmid_edge", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 6'b0);
    b_hold = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("rstmid_cmd_ready", cmd_ready, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    chk("rstmid_no_rsp", rsp_valid, 1'b0);
    chk("rstmid_no_retry", {aw_hs - p_aw, w_hs - p_w, b_hs - p_b, ar_hs - p_ar}, 128'h0);

    // Normal traffic resumes after the abort.
    cfg_rdata = 32'hCAFE_0042;
    do_cmd(1'b0, 32'h18, 32'h0, 32'hCAFE_0042, 1'b0, 2, 0);

`ifdef AXIL_CFG_TIMEOUT_EN
    // Silent slave: watchdog ends the read with an error.
    silent = 1'b1;
    repeat (2) @(posedge clk);
    p_ar = ar_hs;
    do_cmd(1'b0, 32'h50, 32'h0, 32'h0, 1'b1, 16, 0);
    chk("tmo_no_ar_hs", ar_hs, p_ar);
    chk("tmo_valids", {arvalid, rready}, 2'b00);
    silent = 1'b0;
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Absolute time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/axil_cfg_master.md
AXIL_CFG_MASTER -- requirements
Module: axil_cfg_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default `CSR_ADDR_WIDTH, AXI4-Lite address width.
REQ-002 SHALL have parameter DATA_WIDTH, default `DATA_WIDTH, AXI4-Lite data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, watchdog limit (used only when AXIL_CFG_TIMEOUT_EN is defined).
REQ-004 SHALL have port clk  in  1  single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port cmd_valid  in  1  command request.
REQ-007 SHALL have port cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-008 SHALL have port cmd_write  in  1  1 = register write, 0 = register read.
REQ-009 SHALL have port cmd_addr  in  ADDR_WIDTH  byte address of the CSR.
REQ-010 SHALL have port cmd_wdata  in  DATA_WIDTH  write data.
REQ-011 SHALL have port rsp_valid  out  1  response available.
REQ-012 SHALL have port rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high.
REQ-013 SHALL have port rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
REQ-014 SHALL have port rsp_err  out  1  1 when BRESP/RRESP != OKAY, or on timeout.
REQ-015 SHALL have AW channel ports: m_axi_awaddr out ADDR_WIDTH, m_axi_awprot out 3, m_axi_awvalid out 1, m_axi_awready in 1.
REQ-016 SHALL have W channel ports: m_axi_wdata out DATA_WIDTH, m_axi_wstrb out DATA_WIDTH/8, m_axi_wvalid out 1, m_axi_wready in 1.
REQ-017 SHALL have B channel ports: m_axi_bresp in 2, m_axi_bvalid in 1, m_axi_bready out 1.
REQ-018 SHALL have AR channel ports: m_axi_araddr out ADDR_WIDTH, m_axi_arprot out 3, m_axi_arvalid out 1, m_axi_arready in 1.
REQ-019 SHALL have R channel ports: m_axi_rdata in DATA_WIDTH, m_axi_rresp in 2, m_axi_rvalid in 1, m_axi_rready out 1.

Function
REQ-020 SHALL implement states IDLE, WRITE, WRESP, READ, RDATA and RESP, with at most one outstanding transaction.
REQ-021 SHALL assert cmd_ready only in IDLE; on acceptance it SHALL register addr/wdata and go to WRITE if cmd_write=1, else to READ.
REQ-022 In WRITE, SHALL assert awvalid and wvalid in the same cycle and track per-channel acceptance flags. Each valid drops the cycle after its own handshake; AW and W may complete in either order or together.
REQ-023 SHALL move from WRITE to WRESP once both AW and W have handshaked, and hold bready=1 in WRESP only.
REQ-024 On the B handshake, SHALL capture rsp_err = (bresp != 2'b00) and rsp_rdata = 0, then go to RESP.
REQ-025 In READ, SHALL hold arvalid until arready, then go to RDATA with rready=1.
REQ-026 On the R handshake, SHALL capture rdata and rsp_err = (rresp != 2'b00), then go to RESP.
REQ-027 In RESP, SHALL hold rsp_valid and the response stable until rsp_ready, then return to IDLE.
REQ-028 SHALL drive wstrb = all ones and awprot = arprot = 3'b000.
REQ-029 SHALL keep AXI valid signals and address/data stable while a valid is high and unacknowledged (AXI rule); valids SHALL NOT depend combinationally on the ready inputs.
REQ-030 Minimum latency: a write with AW/W/B ready at once gives rsp_valid 3 cycles after cmd acceptance; a read gives rsp_valid 2 cycles after cmd acceptance.

Reset
REQ-031 Asserting rst_n low at any time, including mid-transaction, SHALL force IDLE immediately. All valid/ready outputs go to 0 except cmd_ready, which goes to 1 on deassertion; rsp_rdata, rsp_err, addresses and data reset to 0.
REQ-032 SHALL not retry an aborted transaction after reset.

Configuration
REQ-033 With AXIL_CFG_TIMEOUT_EN defined, a counter SHALL clear on entry to WRITE or READ and increment each cycle in WRITE, WRESP, READ and RDATA. On reaching TIMEOUT_CYCLES it SHALL drop all AXI valid/ready outputs and go to RESP with rsp_err=1 and rsp_rdata=0.
REQ-034 Without AXIL_CFG_TIMEOUT_EN, no counter SHALL exist and the block SHALL wait indefinitely.

Structure
REQ-035 The state enum typedef and the AXI response constants (OKAY=2'b00, SLVERR=2'b10) SHALL live in a shared package; widths SHALL come from defines.sv.
REQ-036 The block SHALL be a single module with no sub-modules.

Verification
REQ-037 Write 0x0000_0005 to 0x08 with slave ready always high -> one AW and one W handshake, bresp=0, rsp_valid 3 cycles after acceptance, rsp_err=0.
REQ-038 Write with wready delayed 4 cycles after awready -> awvalid drops after its handshake, wvalid held with stable wdata, exactly one handshake per channel.
REQ-039 Read 0x10, slave returns 0xDEAD_BEEF with rresp=0 -> rsp_rdata=0xDEADBEEF, rsp_err=0; with rresp=2'b10 -> rsp_err=1.
REQ-040 rsp_ready held low 5 cycles -> rsp_valid and data stable, cmd_ready=0 throughout.
REQ-041 rst_n pulsed low during WRESP -> all valids 0 next edge, cmd_ready=1 after release; with AXIL_CFG_TIMEOUT_EN and TIMEOUT_CYCLES=16, a silent slave gives rsp_err=1 after 16 cycles.
